// File: rtl/cpu_pkg.sv
// Shared decode definitions for the lab CPU: opcode set, operand usage per opcode,
// and the bit positions of instruction fields.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3,
    OP_XOR = 4'd4,  OP_SHL = 4'd5,  OP_LDI = 4'd6,  OP_LD  = 4'd7,
    OP_ST  = 4'd8,  OP_BEQ = 4'd9,  OP_JMP = 4'd10, OP_MOV = 4'd11,
    OP_NOT = 4'd12, OP_R13 = 4'd13, OP_R14 = 4'd14, OP_R15 = 4'd15
  } opcode_e;

  localparam int OPC_HI   = 3;
  localparam int OPC_LO   = 0;
  localparam int RX_HI    = 7;
  localparam int RX_LO    = 5;
  localparam int RY_HI    = 10;
  localparam int RY_LO    = 8;
  localparam int IMM8_HI  = 15;
  localparam int IMM8_LO  = 8;
  localparam int IMM11_HI = 15;
  localparam int IMM11_LO = 5;

  function automatic logic reads_rx(opcode_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_ST, OP_BEQ, OP_NOT:          reads_rx = 1'b1;
      default:                                reads_rx = 1'b0;
    endcase
  endfunction

  function automatic logic reads_ry(opcode_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_LD, OP_ST, OP_BEQ, OP_MOV:           reads_ry = 1'b1;
      default:                                reads_ry = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rx(opcode_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_LDI, OP_LD, OP_MOV, OP_NOT:  writes_rx = 1'b1;
      default:                                writes_rx = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set at issue,
// cleared at writeback. A set and clear of the same register in one cycle leaves it set.
module decode_stage_scoreboard #(
  parameter int NUMREGS = 8,
  parameter int RB      = $clog2(NUMREGS)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_set,
  input  logic [RB-1:0]      i_set_addr,
  input  logic               i_clr,
  input  logic [RB-1:0]      i_clr_addr,
  output logic [NUMREGS-1:0] o_pend
);

  logic [NUMREGS-1:0] r_pend;
  logic [NUMREGS-1:0] w_set_mask;
  logic [NUMREGS-1:0] w_clr_mask;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set) w_set_mask[i_set_addr] = 1'b1;
    if (i_clr) w_clr_mask[i_clr_addr] = 1'b1;
  end

  // Set applied after clear: the issuing instruction is younger than the one retiring.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_pend <= '0;
    else         r_pend <= (r_pend & ~w_clr_mask) | w_set_mask;
  end

  assign o_pend = r_pend;

endmodule

// File: rtl/decode_stage.sv
// Decode stage: one-entry hold register, RAW/WAW hazard stall against the pending-write
// scoreboard, regfile read addressing and decoded-field hand-off to execute.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUMREGS = 8,
  parameter int RB      = $clog2(NUMREGS)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_instr,
  input  logic [WIDTH-1:0] i_pc,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_flush,
  input  logic             i_wb_write,
  input  logic [RB-1:0]    i_wb_addr,
  output logic [RB-1:0]    o_rf_addrx,
  output logic [RB-1:0]    o_rf_addry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_pc,
  output logic [3:0]       o_opcode,
  output logic [RB-1:0]    o_rx,
  output logic [RB-1:0]    o_ry,
  output logic [WIDTH-1:0] o_imm8,
  output logic [WIDTH-1:0] o_imm11,
  output logic             o_writes_rx,
  output logic             o_stall
);

  logic             r_hv;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_pc;

  opcode_e            w_op;
  logic [RB-1:0]      w_rx;
  logic [RB-1:0]      w_ry;
  logic [NUMREGS-1:0] w_pend;
  logic               w_hazard;
  logic               w_fire;
  logic               w_accept;
  logic               w_unused_bit;

  assign w_op         = opcode_e'(r_instr[OPC_HI:OPC_LO]);
  assign w_rx         = r_instr[RX_HI:RX_LO];
  assign w_ry         = r_instr[RY_HI:RY_LO];
  assign w_unused_bit = r_instr[4];

  // Registered pend only: a same-cycle writeback is not yet readable from the regfile.
  assign w_hazard = r_hv & ((((reads_rx(w_op) | writes_rx(w_op)) & w_pend[w_rx])) |
                            (reads_ry(w_op) & w_pend[w_ry]));

  assign o_valid  = r_hv & ~w_hazard & ~i_flush;
  assign o_stall  = r_hv & w_hazard;
  assign w_fire   = o_valid & i_ready;
  assign o_ready  = ~r_hv | w_fire;
  assign w_accept = i_valid & o_ready & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hv    <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_hv <= 1'b0;
    end else if (w_accept) begin
      r_hv    <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (w_fire) begin
      r_hv <= 1'b0;
    end
  end

  decode_stage_scoreboard #(.NUMREGS(NUMREGS), .RB(RB)) u_sb (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_set      (w_fire & writes_rx(w_op)),
    .i_set_addr (w_rx),
    .i_clr      (i_wb_write),
    .i_clr_addr (i_wb_addr),
    .o_pend     (w_pend)
  );

  assign o_rf_addrx  = w_rx;
  assign o_rf_addry  = w_ry;
  assign o_rx        = w_rx;
  assign o_ry        = w_ry;
  assign o_pc        = r_pc;
  assign o_opcode    = r_instr[OPC_HI:OPC_LO];
  assign o_writes_rx = r_hv & writes_rx(w_op);
  assign o_imm8      = {{(WIDTH-8){r_instr[IMM8_HI]}},   r_instr[IMM8_HI:IMM8_LO]};
  assign o_imm11     = {{(WIDTH-11){r_instr[IMM11_HI]}}, r_instr[IMM11_HI:IMM11_LO]};

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: reference model predicts handshake/stall per cycle and queues
// expected issued instructions; a monitor pops and compares on every fire.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_instr, i_pc;
  logic        i_valid, i_flush, i_wb_write, i_ready;
  logic [2:0]  i_wb_addr;
  logic        o_ready, o_valid, o_writes_rx, o_stall;
  logic [2:0]  o_rf_addrx, o_rf_addry, o_rx, o_ry;
  logic [15:0] o_pc, o_imm8, o_imm11;
  logic [3:0]  o_opcode;

  decode_stage #(.WIDTH(16), .NUMREGS(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_instr(i_instr), .i_pc(i_pc), .i_valid(i_valid),
    .o_ready(o_ready), .i_flush(i_flush), .i_wb_write(i_wb_write), .i_wb_addr(i_wb_addr),
    .o_rf_addrx(o_rf_addrx), .o_rf_addry(o_rf_addry), .o_valid(o_valid), .i_ready(i_ready),
    .o_pc(o_pc), .o_opcode(o_opcode), .o_rx(o_rx), .o_ry(o_ry), .o_imm8(o_imm8),
    .o_imm11(o_imm11), .o_writes_rx(o_writes_rx), .o_stall(o_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [3:0]  op;
    logic [2:0]  rx, ry;
    logic [15:0] i8, i11;
    logic        wr;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Model state: held instruction and set of registers with a write in flight.
  logic        m_hv = 1'b0;
  logic [15:0] m_instr = '0, m_pc = '0;
  logic [7:0]  m_pend = '0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  // {reads rx, reads ry, writes rx} per opcode of the lab ISA.
  function automatic logic [2:0] props(logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: return 3'b111;
      4'd5, 4'd12:                  return 3'b101;
      4'd6:                         return 3'b001;
      4'd7, 4'd11:                  return 3'b011;
      4'd8, 4'd9:                   return 3'b110;
      default:                      return 3'b000;
    endcase
  endfunction

  function automatic logic [15:0] sext(int v, int bits);
    int r;
    r = (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    return r[15:0];
  endfunction

  function automatic logic [15:0] mk(logic [3:0] op, logic [2:0] rx, logic [2:0] ry);
    return {5'b0, ry, rx, 1'b0, op};
  endfunction

  // Reference model: compares handshake outputs, then advances its own state.
  always @(negedge clk) begin : model
    logic [2:0] p;
    logic [2:0] rx, ry;
    logic haz, ev, fire, er;
    exp_t e;
    int v;
    if (rst) begin
      m_hv = 1'b0; m_instr = '0; m_pc = '0; m_pend = '0;
      q.delete();
    end else begin
      p  = props(m_instr[3:0]);
      rx = m_instr[7:5];
      ry = m_instr[10:8];
      haz  = m_hv && (((p[2] || p[0]) && m_pend[rx]) || (p[1] && m_pend[ry]));
      ev   = m_hv && !haz && !i_flush;
      fire = ev && i_ready;
      er   = !m_hv || fire;
      chk("valid", o_valid, ev);
      chk("stall", o_stall, m_hv && haz);
      chk("ready", o_ready, er);
      if (m_hv) chk("rf_addr", {o_rf_addrx, o_rf_addry}, {rx, ry});
      if (i_wb_write) m_pend[i_wb_addr] = 1'b0;
      if (fire && p[0]) m_pend[rx] = 1'b1;
      if (i_flush) begin
        if (m_hv && q.size() > 0) void'(q.pop_front());
        m_hv = 1'b0;
      end else if (i_valid && er) begin
        e.pc = i_pc; e.op = i_instr[3:0]; e.rx = i_instr[7:5]; e.ry = i_instr[10:8];
        v = i_instr[15:8];  e.i8  = sext(v, 8);
        v = i_instr[15:5];  e.i11 = sext(v, 11);
        e.wr = props(i_instr[3:0]) == 3'b000 ? 1'b0 : props(i_instr[3:0]) >> 0 & 3'b001 ? 1'b1 : 1'b0;
        q.push_back(e);
        m_hv = 1'b1; m_instr = i_instr; m_pc = i_pc;
      end else if (fire) begin
        m_hv = 1'b0;
      end
    end
  end

  // Monitor: every handed-off instruction must match the oldest expected entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && o_valid === 1'b1 && i_ready) begin
      if (q.size() == 0) chk("issue_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("issue_pc", o_pc, e.pc);
        chk("issue_fields", {o_opcode, o_rx, o_ry, o_writes_rx}, {e.op, e.rx, e.ry, e.wr});
        chk("issue_imm8", o_imm8, e.i8);
        chk("issue_imm11", o_imm11, e.i11);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    i_valid = 0; i_flush = 0; i_ready = 1;
    repeat (2) begin
      step();
      for (int r = 0; r < 8; r++) if (m_pend[r]) begin
        i_wb_write = 1; i_wb_addr = 3'(r); step();
      end
      i_wb_write = 0; step();
    end
  endtask

  initial begin
    rst = 1; i_valid = 0; i_flush = 0; i_wb_write = 0; i_wb_addr = 0; i_ready = 0;
    i_instr = 0; i_pc = 0;
    repeat (2) step();
    rst = 0; #1;
    chk("rst_valid", o_valid, 0); chk("rst_ready", o_ready, 1); chk("rst_stall", o_stall, 0);
    chk("rst_fields", {o_pc, o_opcode, o_rx, o_ry, o_writes_rx}, 0);
    chk("rst_imm", {o_imm8, o_imm11}, 0); chk("rst_pend", dut.u_sb.o_pend, 0);

    // back-to-back independent
    i_ready = 1; i_valid = 1; i_instr = mk(0, 1, 2); i_pc = 16'h0010; step();
    i_instr = mk(0, 3, 4); i_pc = 16'h0011; #1;
    chk("b2b_first", {o_valid, o_ready, o_stall}, 3'b110); step();
    i_valid = 0; #1;
    chk("b2b_second", {o_valid, o_stall}, 2'b10); drain();

    // RAW on r1, no bypass during the writeback cycle
    i_valid = 1; i_instr = mk(0, 1, 2); i_pc = 16'h0020; step();
    i_instr = mk(0, 4, 1); i_pc = 16'h0021; step();
    i_valid = 0;
    repeat (3) begin #1; chk("raw_stall", {o_stall, o_valid}, 2'b10); step(); end
    i_wb_write = 1; i_wb_addr = 1; #1; chk("raw_wb_cycle", {o_stall, o_valid}, 2'b10); step();
    i_wb_write = 0; #1; chk("raw_issue", {o_stall, o_valid}, 2'b01); step(); drain();

    // set/clear collision on r5
    i_valid = 1; i_instr = mk(0, 5, 6); i_pc = 16'h0030; step();
    i_valid = 0; i_wb_write = 1; i_wb_addr = 5; #1; chk("coll_fire", o_valid, 1); step();
    i_wb_write = 0; #1; chk("coll_pend5", dut.u_sb.o_pend[5], 1); drain();

    // flush with held and incoming instruction; pend untouched
    i_valid = 1; i_instr = mk(6, 6, 0); i_pc = 16'h0039; step();
    i_instr = mk(13, 0, 0); i_pc = 16'h0040; step();
    i_ready = 0; i_instr = mk(0, 2, 3); i_pc = 16'h0041; i_flush = 1; #1;
    chk("flush_valid", o_valid, 0); step();
    i_flush = 0; i_valid = 0; #1;
    chk("flush_after", {o_valid, o_ready}, 2'b01); chk("flush_pend", dut.u_sb.o_pend, 8'h40);
    drain();

    // backpressure, sign extension
    i_ready = 0; i_valid = 1; i_instr = 16'hFF05; i_pc = 16'h0050; step();
    i_valid = 0;
    repeat (3) begin
      #1; chk("bp_valid", o_valid, 1); chk("bp_pc_op", {o_pc, o_opcode}, {16'h0050, 4'h5});
      chk("bp_imm8", o_imm8, 16'hFFFF); chk("bp_imm11", o_imm11, 16'hFFF8); step();
    end
    drain();

    // reset mid-stream with r2,r3 pending and an instruction held
    i_valid = 1; i_instr = mk(6, 2, 0); i_pc = 16'h0060; step();
    i_instr = mk(6, 3, 0); i_pc = 16'h0061; step();
    i_instr = mk(13, 0, 0); i_pc = 16'h0062; step();
    i_ready = 0; i_valid = 0; #1;
    chk("mid_pend", dut.u_sb.o_pend, 8'h0C); chk("mid_hv", o_valid, 1);
    rst = 1; step(); rst = 0; #1;
    chk("mid_rst", {o_valid, o_ready, o_stall}, 3'b010); chk("mid_rst_pend", dut.u_sb.o_pend, 0);

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      i_valid = ($urandom % 4) != 0;
      i_instr = 16'($urandom);
      i_pc    = 16'($urandom);
      i_ready = ($urandom % 4) != 0;
      i_flush = ($urandom % 16) == 0;
      i_wb_write = 0;
      if (m_pend != 0 && ($urandom % 2)) begin
        for (int t = 0; t < 16 && !i_wb_write; t++) begin
          i_wb_addr = 3'($urandom % 8);
          if (m_pend[i_wb_addr]) i_wb_write = 1;
        end
      end else if (($urandom % 8) == 0) begin
        i_wb_write = 1; i_wb_addr = 3'($urandom % 8);
      end
      step();
    end
    drain();
    chk("final_queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
